// File: rtl/ysyx_23060077_mem_arbiter_pkg.sv
// rtl/ysyx_23060077_mem_arbiter_pkg.sv - arbiter state encodings, grant IDs and AXI field widths
package ysyx_23060077_mem_arbiter_pkg;

  localparam int AXI_SIZE_W = 3;
  localparam int AXI_LEN_W  = 8;

  localparam logic [AXI_SIZE_W-1:0] AXI_SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IFU  = 2'd1,
    ARB_LSU  = 2'd2
  } arb_state_e;

  // Bit positions in the request/grant vectors
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

  // Encoding of the last_grant register
  localparam logic LAST_IFU = 1'b0;
  localparam logic LAST_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060077_arb_pick.sv
// rtl/ysyx_23060077_arb_pick.sv - combinational 2-way picker, LSU-first or round-robin on a tie
module ysyx_23060077_arb_pick
  import ysyx_23060077_mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       rr_en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[GNT_LSU] && req_i[GNT_IFU]) begin
      if (rr_en_i && (last_grant_i == LAST_LSU)) begin
        gnt_o[GNT_IFU] = 1'b1;
      end else begin
        gnt_o[GNT_LSU] = 1'b1;
      end
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/ysyx_23060077_mem_arbiter.sv
// rtl/ysyx_23060077_mem_arbiter.sv - IFU/LSU arbiter for the single memory master port
// YSYX_23060077_ARB_RR_EN selects round-robin on a tie; otherwise fixed LSU priority.
module ysyx_23060077_mem_arbiter
  import ysyx_23060077_mem_arbiter_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [AXI_LEN_W-1:0] IFU_LEN    = 8'd3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_ready_o,
  output logic                  ifu_last_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  lsu_valid_i,
  input  logic                  lsu_wen_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [AXI_SIZE_W-1:0] lsu_size_i,
  output logic                  lsu_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wen_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [AXI_SIZE_W-1:0] mem_size_o,
  output logic [AXI_LEN_W-1:0]  mem_len_o,
  input  logic                  mem_ready_i,
  input  logic                  mem_last_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  arb_state_e            state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_SIZE_W-1:0] size_q, size_d;
  logic [AXI_LEN_W-1:0]  len_q, len_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       last_grant;
  logic       rr_en;
  logic       done;

  assign req  = {lsu_valid_i, ifu_valid_i};
  assign done = mem_ready_i & mem_last_i;

`ifdef YSYX_23060077_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  assign last_grant = last_grant_q;
  assign rr_en      = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= LAST_IFU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign last_grant = LAST_IFU;
  assign rr_en      = 1'b0;
`endif

  ysyx_23060077_arb_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_grant),
    .rr_en_i      (rr_en),
    .gnt_o        (gnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    len_d   = len_q;
`ifdef YSYX_23060077_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt[GNT_LSU]) begin
          state_d = ARB_LSU;
          valid_d = 1'b1;
          wen_d   = lsu_wen_i;
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          size_d  = lsu_size_i;
          len_d   = '0;
        end else if (gnt[GNT_IFU]) begin
          state_d = ARB_IFU;
          valid_d = 1'b1;
          wen_d   = 1'b0;
          addr_d  = ifu_addr_i;
          wdata_d = '0;
          size_d  = AXI_SIZE_WORD;
          len_d   = IFU_LEN;
        end
      end
      ARB_IFU, ARB_LSU: begin
        // Only the final beat releases the port; intermediate beats just stream through.
        if (done) begin
          state_d = ARB_IDLE;
          valid_d = 1'b0;
`ifdef YSYX_23060077_ARB_RR_EN
          last_grant_d = (state_q == ARB_LSU) ? LAST_LSU : LAST_IFU;
`endif
        end
      end
      default: begin
        state_d = ARB_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign mem_valid_o = valid_q;
  assign mem_wen_o   = wen_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_size_o  = size_q;
  assign mem_len_o   = len_q;

  assign ifu_ready_o = (state_q == ARB_IFU) & mem_ready_i;
  assign ifu_last_o  = ifu_ready_o & mem_last_i;
  assign lsu_ready_o = (state_q == ARB_LSU) & done;
  assign ifu_rdata_o = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_ysyx_23060077_mem_arbiter.sv
// tb/tb_ysyx_23060077_mem_arbiter.sv - self-checking bench for the IFU/LSU memory arbiter
module tb_ysyx_23060077_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_valid_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_ready_o;
  logic        ifu_last_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_valid_i;
  logic        lsu_wen_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [2:0]  lsu_size_i;
  logic        lsu_ready_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_valid_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [2:0]  mem_size_o;
  logic [7:0]  mem_len_o;
  logic        mem_ready_i;
  logic        mem_last_i;
  logic [31:0] mem_rdata_i;

  ysyx_23060077_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .ifu_valid_i (ifu_valid_i),
    .ifu_addr_i  (ifu_addr_i),
    .ifu_ready_o (ifu_ready_o),
    .ifu_last_o  (ifu_last_o),
    .ifu_rdata_o (ifu_rdata_o),
    .lsu_valid_i (lsu_valid_i),
    .lsu_wen_i   (lsu_wen_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_size_i  (lsu_size_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rdata_o (lsu_rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_wen_o   (mem_wen_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_size_o  (mem_size_o),
    .mem_len_o   (mem_len_o),
    .mem_ready_i (mem_ready_i),
    .mem_last_i  (mem_last_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who was served last, and what the port should carry now
  logic        lg_lsu;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;
  logic        exp_wen;
  logic [2:0]  exp_size;
  logic [7:0]  exp_len;

  typedef struct {
    bit          is_lsu;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          stalls;
    int          nolast;
    logic [31:0] rdata;
    logic        exp_wen;
    logic [2:0]  exp_size;
    logic [7:0]  exp_len;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_lsu_first(bit want_i, bit want_l, bit last_was_lsu);
    if (want_i && want_l) begin
`ifdef YSYX_23060077_ARB_RR_EN
      return !last_was_lsu;
`else
      return 1'b1 | last_was_lsu;
`endif
    end
    return want_l;
  endfunction

  task automatic req_ifu(input logic [31:0] a);
    ifu_valid_i = 1'b1;
    ifu_addr_i  = a;
  endtask

  task automatic req_lsu(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    lsu_valid_i = 1'b1;
    lsu_wen_i   = w;
    lsu_addr_i  = a;
    lsu_wdata_i = d;
    lsu_size_i  = s;
  endtask

  task automatic chk_fields();
    chk("hold_valid", mem_valid_o, 1'b1);
    chk("hold_addr", mem_addr_o, exp_addr);
    chk("hold_wen", mem_wen_o, exp_wen);
    chk("hold_size", mem_size_o, exp_size);
    chk("hold_len", mem_len_o, exp_len);
    if (exp_wen) chk("hold_wdata", mem_wdata_o, exp_wdata);
  endtask

  task automatic expect_grant(input bit is_lsu);
    int lat;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_valid_o) begin
        lat = k;
        break;
      end
    end
    chk("grant_latency", lat, 1);
    if (is_lsu) begin
      exp_addr  = lsu_addr_i;
      exp_wen   = lsu_wen_i;
      exp_wdata = lsu_wdata_i;
      exp_size  = lsu_size_i;
      exp_len   = 8'd0;
    end else begin
      exp_addr  = ifu_addr_i;
      exp_wen   = 1'b0;
      exp_wdata = 32'd0;
      exp_size  = 3'd2;
      exp_len   = 8'd3;
    end
    chk_fields();
  endtask

  // Acts as the slave for one granted transaction; optionally raises an LSU load mid-burst.
  task automatic serve(input bit is_lsu, input int stalls, input int nolast,
                       input logic [31:0] rbase, input int inject_at);
    int          nbeats;
    logic [31:0] d;
    bit          fin;
    nbeats = is_lsu ? nolast + 1 : 4;
    for (int b = 0; b < nbeats; b++) begin
      for (int s = 0; s < stalls; s++) begin
        @(negedge clk);
        mem_ready_i = 1'b0;
        mem_last_i  = 1'b0;
        #1;
        chk("stall_ifu_ready", ifu_ready_o, 1'b0);
        chk("stall_lsu_ready", lsu_ready_o, 1'b0);
        chk_fields();
      end
      @(negedge clk);
      if (b == inject_at) req_lsu(1'b0, 32'h8000_0020, 32'h0, 3'd2);
      fin         = (b == nbeats - 1);
      d           = rbase + 32'(b);
      mem_ready_i = 1'b1;
      mem_last_i  = fin;
      mem_rdata_i = d;
      #1;
      chk_fields();
      if (is_lsu) begin
        chk("lsu_ready", lsu_ready_o, fin);
        chk("lsu_side_ifu_ready", ifu_ready_o, 1'b0);
        if (fin) chk("lsu_rdata", lsu_rdata_o, d);
      end else begin
        chk("ifu_ready", ifu_ready_o, 1'b1);
        chk("ifu_last", ifu_last_o, fin);
        chk("ifu_rdata", ifu_rdata_o, d);
        chk("ifu_side_lsu_ready", lsu_ready_o, 1'b0);
      end
    end
    @(negedge clk);
    mem_ready_i = 1'b0;
    mem_last_i  = 1'b0;
    if (is_lsu) lsu_valid_i = 1'b0;
    else        ifu_valid_i = 1'b0;
    #1;
    chk("idle_after_last", mem_valid_o, 1'b0);
    chk("idle_ifu_ready", ifu_ready_o, 1'b0);
    chk("idle_lsu_ready", lsu_ready_o, 1'b0);
    lg_lsu = is_lsu;
  endtask

  initial begin
    bit first;
    bit pend_i;
    bit pend_l;

    vecs[0] = '{1'b0, 1'b0, 32'h3000_0000, 32'h0,         3'd2, 0, 0, 32'hA000_0000, 1'b0, 3'd2, 8'd3};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 3'd2, 4, 0, 32'h0,         1'b1, 3'd2, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0003, 32'h0,         3'd0, 1, 0, 32'h0000_00AB, 1'b0, 3'd0, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 32'h3000_0100, 32'h0,         3'd2, 1, 0, 32'hB000_0000, 1'b0, 3'd2, 8'd3};
    vecs[4] = '{1'b1, 1'b1, 32'h8000_0042, 32'h0000_CAFE, 3'd1, 0, 3, 32'h5555_0000, 1'b1, 3'd1, 8'd0};

    reset       = 1'b0;
    ifu_valid_i = 1'b1;
    ifu_addr_i  = 32'h1234_0000;
    lsu_valid_i = 1'b1;
    lsu_wen_i   = 1'b1;
    lsu_addr_i  = 32'h8000_0000;
    lsu_wdata_i = 32'h1;
    lsu_size_i  = 3'd2;
    mem_ready_i = 1'b1;
    mem_last_i  = 1'b1;
    mem_rdata_i = 32'h0;
    lg_lsu      = 1'b0;
    exp_addr    = 32'h0;
    exp_wdata   = 32'h0;
    exp_wen     = 1'b0;
    exp_size    = 3'd0;
    exp_len     = 8'd0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", mem_valid_o, 1'b0);
    chk("rst_wen", mem_wen_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    chk("rst_size", mem_size_o, 3'd0);
    chk("rst_len", mem_len_o, 8'd0);
    chk("rst_ifu_ready", ifu_ready_o, 1'b0);
    chk("rst_ifu_last", ifu_last_o, 1'b0);
    chk("rst_lsu_ready", lsu_ready_o, 1'b0);

    @(negedge clk);
    ifu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    mem_last_i  = 1'b0;
    reset       = 1'b1;

    // Request dropped before any grant edge must not be granted
    @(negedge clk);
    req_ifu(32'h3000_0900);
    #2;
    ifu_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_before_grant", mem_valid_o, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (vecs[i].is_lsu) req_lsu(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].size);
      else                req_ifu(vecs[i].addr);
      expect_grant(vecs[i].is_lsu);
      chk("vec_addr", mem_addr_o, vecs[i].addr);
      chk("vec_wen", mem_wen_o, vecs[i].exp_wen);
      chk("vec_size", mem_size_o, vecs[i].exp_size);
      chk("vec_len", mem_len_o, vecs[i].exp_len);
      serve(vecs[i].is_lsu, vecs[i].stalls, vecs[i].nolast, vecs[i].rdata, -1);
    end

    // Simultaneous requests; last grant was the LSU
    @(negedge clk);
    req_ifu(32'h3000_0200);
    req_lsu(1'b1, 32'h8000_0030, 32'h0BAD_F00D, 3'd2);
    first = model_lsu_first(1'b1, 1'b1, lg_lsu);
    expect_grant(first);
    serve(first, 1, 0, 32'hC000_0000, -1);
    expect_grant(!first);
    serve(!first, 0, 0, 32'hC100_0000, -1);

    // LSU load arrives during an IFU burst and waits for the burst's last beat
    @(negedge clk);
    req_ifu(32'h3000_0300);
    expect_grant(1'b0);
    serve(1'b0, 0, 0, 32'hD000_0000, 1);
    expect_grant(1'b1);
    chk("mid_lsu_addr", mem_addr_o, 32'h8000_0020);
    serve(1'b1, 1, 0, 32'h1234_5678, -1);

    // Reset during beat 2 of an IFU burst
    @(negedge clk);
    req_ifu(32'h3000_0400);
    expect_grant(1'b0);
    @(negedge clk);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hE000_0000;
    #1;
    chk("rstmid_beat1", ifu_ready_o, 1'b1);
    @(negedge clk);
    mem_rdata_i = 32'hE000_0001;
    #1;
    chk("rstmid_beat2", ifu_ready_o, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_valid", mem_valid_o, 1'b0);
    chk("rstmid_ifu_ready", ifu_ready_o, 1'b0);
    chk("rstmid_len", mem_len_o, 8'd0);
    @(negedge clk);
    reset       = 1'b1;
    ifu_valid_i = 1'b0;
    mem_ready_i = 1'b0;
    lg_lsu      = 1'b0;
    @(negedge clk);
    req_lsu(1'b0, 32'h8000_0050, 32'h0, 3'd2);
    expect_grant(1'b1);
    serve(1'b1, 0, 0, 32'h7777_0000, -1);

    // Randomized traffic against the arbitration model
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      pend_i = 1'($urandom % 2);
      pend_l = 1'($urandom % 2);
      if (!pend_i && !pend_l) pend_i = 1'b1;
      if (pend_i) req_ifu($urandom & 32'hFFFF_FFFC);
      if (pend_l) req_lsu(1'($urandom % 2), $urandom, $urandom, 3'($urandom_range(0, 2)));
      while (pend_i || pend_l) begin
        first = model_lsu_first(pend_i, pend_l, lg_lsu);
        expect_grant(first);
        serve(first, $urandom_range(0, 2), first ? $urandom_range(0, 2) : 0, $urandom, -1);
        if (first) pend_l = 1'b0;
        else       pend_i = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060077_mem_arbiter.md
Name: ysyx_23060077_mem_arbiter

Overview:
- Shares the core's single memory master port between the IFU (instruction fetch, read-only, burst) and the LSU (single-beat load/store).
- Grants one requester at a time and registers that requester's request onto the downstream port.
- Returns the handshake and data to the granted requester only.
- Sits between the IFU/LSU and the AXI master bridge.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
IFU_LEN, 8'd3, burst length field (beats-1) driven for IFU fetches

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ifu_valid_i  in  1  IFU read request, held until ifu_last_o
ifu_addr_i  in  ADDR_WIDTH  IFU fetch address
ifu_ready_o  out  1  IFU beat accepted/data valid
ifu_last_o  out  1  final IFU beat
ifu_rdata_o  out  DATA_WIDTH  IFU read data
lsu_valid_i  in  1  LSU request, held until lsu_ready_o
lsu_wen_i  in  1  1 = store, 0 = load
lsu_addr_i  in  ADDR_WIDTH  LSU address
lsu_wdata_i  in  DATA_WIDTH  store data
lsu_size_i  in  3  AXI size code (0/1/2)
lsu_ready_o  out  1  LSU transaction complete
lsu_rdata_o  out  DATA_WIDTH  load data
mem_valid_o  out  1  downstream request valid
mem_wen_o  out  1  downstream write
mem_addr_o  out  ADDR_WIDTH  downstream address
mem_wdata_o  out  DATA_WIDTH  downstream write data
mem_size_o  out  3  downstream size
mem_len_o  out  8  downstream burst length (beats-1)
mem_ready_i  in  1  downstream beat handshake
mem_last_i  in  1  downstream final beat
mem_rdata_i  in  DATA_WIDTH  downstream read data

Behaviour:
- Reset (reset==0, async): state IDLE; mem_valid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_size_o, mem_len_o = 0; last_grant = IFU. All ready/last outputs are 0 because nothing is granted.
- FSM states: IDLE, GNT_IFU, GNT_LSU.
- IDLE:
  - Default arbitration is fixed priority, LSU over IFU.
  - On the granting edge, latch the request fields and set mem_valid_o=1. mem_valid_o is therefore high one cycle after the request is seen.
  - IFU grant drives: wen=0, size=3'd2, len=IFU_LEN.
  - LSU grant drives: wen=lsu_wen_i, size=lsu_size_i, len=0.
- GNT_x:
  - mem_valid_o and the latched fields stay constant until a cycle with mem_ready_i & mem_last_i.
  - On that edge: mem_valid_o<=0, state<=IDLE, last_grant<=x.
  - Minimum gap from the last beat to the next mem_valid_o is 2 cycles (one IDLE cycle, then the grant edge).
- Responses (combinational):
  - ifu_ready_o = GNT_IFU & mem_ready_i; ifu_last_o = ifu_ready_o & mem_last_i.
  - lsu_ready_o = GNT_LSU & mem_ready_i & mem_last_i.
  - ifu_rdata_o = lsu_rdata_o = mem_rdata_i.
  - The non-granted side always sees 0.
- Simultaneous IFU and LSU requests in IDLE: the LSU wins by default; the IFU is served next.
- Requester drops valid before grant: no grant. Requester drops valid after grant: the transaction still completes and its response strobes still pulse.
- mem_ready_i without mem_last_i in GNT_LSU: ignored for completion; state holds.
- Input changes during GNT_x do not alter mem_* outputs.
- Reset mid-transaction: outputs clear immediately and the in-flight response is dropped. The downstream slave shares the same reset.

Optional Feature:
- Macro: YSYX_23060077_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, grant the requester that is not last_grant. A single requester is granted immediately.
- Undefined: fixed LSU priority. The last_grant register is removed.

Decomposition:
- The shared define header holds the state encodings (ARB_IDLE/ARB_IFU/ARB_LSU, 2 bits) and the grant IDs.
- It also reuses the existing AXI size/len width macros.
- One sub-module, ysyx_23060077_arb_pick: combinational 2-way picker. Inputs: req[1:0], last_grant, rr_en. Output: one-hot gnt.

Test Plan:
- IFU only, addr 0x3000_0000, slave answers 4 beats (ready each cycle, last on beat 4):
  - mem_len_o=3 and size=2.
  - ifu_ready_o pulses 4 times; ifu_last_o only on beat 4.
  - FSM back in IDLE the cycle after.
- LSU store sw 0x8000_0010 data 0xDEADBEEF, slave ready&last after 5 cycles:
  - mem_wen_o=1, mem_size_o=2, len=0.
  - lsu_ready_o is a single pulse in that cycle; fields stable throughout.
- IFU and LSU asserted on the same cycle:
  - Without RR_EN: LSU granted first; IFU mem_valid_o rises 2 cycles after LSU completion.
  - With RR_EN and last_grant=LSU: IFU granted first.
- During a GNT_IFU burst, LSU asserts a load 0x8000_0020:
  - The burst is not interrupted.
  - LSU is granted after IFU last; lsu_rdata_o = slave data 0x1234_5678.
- Assert reset=0 mid IFU burst (beat 2):
  - mem_valid_o and ifu_ready_o go 0 without waiting for a clock edge.
  - After release, the first request is granted normally.
- Slave raises mem_ready_i on 3 beats without last during an LSU grant:
  - lsu_ready_o stays 0 and state holds until the beat with last.
